mem_port_arbiter: RTL and testbench

Shares the single main-memory port (12-bit block address, 256-bit block data, AXI-style valid/ready) between the instruction cache (read-only) and the data cache (read + write-back). It sits between both caches and the RAM model. Exactly one transaction is granted at a time, and the grant is held until that transaction completes. A watchdog counter aborts transactions the memory never completes.

---
 rtl/mem_port_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter: shares one memory port between ICache reads and DCache
// reads/write-backs. Optional macro ARB_ROUND_ROBIN_EN selects fair reads.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 256,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_araddr,
  input  logic              i_arvalid,
  output logic              i_arready,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rvalid,
  input  logic              i_rready,
  input  logic [ADDR_W-1:0] d_araddr,
  input  logic              d_arvalid,
  output logic              d_arready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  input  logic              d_rready,
  input  logic [ADDR_W-1:0] d_awaddr,
  input  logic              d_awvalid,
  output logic              d_awready,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_wvalid,
  output logic              d_wready,
  output logic [ADDR_W-1:0] ram_axi_araddr,
  output logic              ram_axi_arvalid,
  input  logic              ram_axi_arready,
  input  logic [DATA_W-1:0] ram_axi_rdata,
  input  logic              ram_axi_rvalid,
  output logic              ram_axi_rready,
  output logic [ADDR_W-1:0] ram_axi_awaddr,
  output logic              ram_axi_awvalid,
  input  logic              ram_axi_awready,
  output logic [DATA_W-1:0] ram_axi_wdata,
  output logic              ram_axi_wvalid,
  input  logic              ram_axi_wready,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    I_RD = 2'b01,
    D_RD = 2'b10,
    D_WR = 2'b11
  } state_t;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t r_state;
  state_t w_next;
  logic   r_timeout_err;
  logic   w_rd_done;
  logic   w_wr_done;
  logic   w_done;
  logic   w_wd_fire;
  logic   w_pick_d;

  assign w_rd_done = ((r_state == I_RD) || (r_state == D_RD)) && ram_axi_rvalid && ram_axi_rready;
  assign w_wr_done = (r_state == D_WR) && ram_axi_awready && ram_axi_wready;
  assign w_done    = w_rd_done || w_wr_done;

`ifdef ARB_ROUND_ROBIN_EN
  // 0 = ICache was served last, 1 = DCache was served last
  logic r_last_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_rd <= 1'b0;
    end else if (w_rd_done) begin
      r_last_rd <= (r_state == D_RD);
    end
  end

  assign w_pick_d = d_arvalid && (!i_arvalid || !r_last_rd);
`else
  assign w_pick_d = d_arvalid;
`endif

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wdog
      logic [CNT_W-1:0] r_wait;

      // Held at zero in IDLE so every grant starts counting from zero
      always_ff @(posedge clk) begin
        if (rst || (r_state == IDLE)) begin
          r_wait <= '0;
        end else if (!w_done) begin
          r_wait <= r_wait + 1'b1;
        end
      end

      assign w_wd_fire = (r_state != IDLE) && !w_done &&
                         (r_wait == CNT_W'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_wdog
      assign w_wd_fire = 1'b0;
    end
  endgenerate

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (d_awvalid && d_wvalid) begin
          w_next = D_WR;
        end else if (w_pick_d) begin
          w_next = D_RD;
        end else if (i_arvalid) begin
          w_next = I_RD;
        end
      end
      default: begin
        if (w_done || w_wd_fire) begin
          w_next = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_wd_fire) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  // Only the current owner is connected to the memory port
  always_comb begin
    i_arready       = 1'b0;
    i_rvalid        = 1'b0;
    i_rdata         = '0;
    d_arready       = 1'b0;
    d_rvalid        = 1'b0;
    d_rdata         = '0;
    d_awready       = 1'b0;
    d_wready        = 1'b0;
    ram_axi_araddr  = '0;
    ram_axi_arvalid = 1'b0;
    ram_axi_rready  = 1'b0;
    ram_axi_awaddr  = '0;
    ram_axi_awvalid = 1'b0;
    ram_axi_wdata   = '0;
    ram_axi_wvalid  = 1'b0;
    case (r_state)
      I_RD: begin
        ram_axi_araddr  = i_araddr;
        ram_axi_arvalid = i_arvalid;
        i_arready       = ram_axi_arready;
        ram_axi_rready  = i_rready;
        i_rvalid        = ram_axi_rvalid;
        i_rdata         = ram_axi_rdata;
        d_rdata         = ram_axi_rdata;
      end
      D_RD: begin
        ram_axi_araddr  = d_araddr;
        ram_axi_arvalid = d_arvalid;
        d_arready       = ram_axi_arready;
        ram_axi_rready  = d_rready;
        d_rvalid        = ram_axi_rvalid;
        i_rdata         = ram_axi_rdata;
        d_rdata         = ram_axi_rdata;
      end
      D_WR: begin
        ram_axi_awaddr  = d_awaddr;
        ram_axi_awvalid = d_awvalid;
        ram_axi_wdata   = d_wdata;
        ram_axi_wvalid  = d_wvalid;
        d_awready       = ram_axi_awready;
        d_wready        = ram_axi_wready;
      end
      default: begin
      end
    endcase
  end

  assign grant       = r_state;
  assign busy        = (r_state != IDLE);
  assign timeout_err = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter: scoreboard bench with a reactive memory model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 256;
  localparam logic [DW-1:0] D040 = {32{8'hA5}};
  localparam logic [DW-1:0] D080 = {32{8'h3C}};
  localparam logic [DW-1:0] D100 = {32{8'h5A}};
  localparam logic [DW-1:0] WDAT = {8{32'hDEADBEEF}};
  localparam logic [DW-1:0] JUNK = {32{8'hEE}};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] i_araddr = '0, d_araddr = '0, d_awaddr = '0;
  logic          i_arvalid = 1'b0, d_arvalid = 1'b0, d_awvalid = 1'b0, d_wvalid = 1'b0;
  logic          i_rready = 1'b1, d_rready = 1'b1;
  logic [DW-1:0] d_wdata = '0;
  logic          i_arready, i_rvalid, d_arready, d_rvalid, d_awready, d_wready;
  logic [DW-1:0] i_rdata, d_rdata;
  logic [AW-1:0] ram_axi_araddr, ram_axi_awaddr;
  logic          ram_axi_arvalid, ram_axi_rready, ram_axi_awvalid, ram_axi_wvalid;
  logic [DW-1:0] ram_axi_wdata;
  logic          ram_axi_arready = 1'b0, ram_axi_rvalid = 1'b0;
  logic          ram_axi_awready = 1'b0, ram_axi_wready = 1'b0;
  logic [DW-1:0] ram_axi_rdata = '0;
  logic [1:0]    grant;
  logic          busy, timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  int mem_mode = 0;  // 0 normal, 1 silent, 2 spray stale rvalid

  typedef struct packed { logic [1:0] g; logic [AW-1:0] a; } ar_t;
  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } aw_t;
  ar_t           exp_ar[$];
  aw_t           exp_aw[$];
  logic [DW-1:0] exp_ir[$];
  logic [DW-1:0] exp_dr[$];

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .i_araddr(i_araddr), .i_arvalid(i_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arvalid(d_arvalid), .d_arready(d_arready),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_rready(d_rready),
    .d_awaddr(d_awaddr), .d_awvalid(d_awvalid), .d_awready(d_awready),
    .d_wdata(d_wdata), .d_wvalid(d_wvalid), .d_wready(d_wready),
    .ram_axi_araddr(ram_axi_araddr), .ram_axi_arvalid(ram_axi_arvalid),
    .ram_axi_arready(ram_axi_arready), .ram_axi_rdata(ram_axi_rdata),
    .ram_axi_rvalid(ram_axi_rvalid), .ram_axi_rready(ram_axi_rready),
    .ram_axi_awaddr(ram_axi_awaddr), .ram_axi_awvalid(ram_axi_awvalid),
    .ram_axi_awready(ram_axi_awready), .ram_axi_wdata(ram_axi_wdata),
    .ram_axi_wvalid(ram_axi_wvalid), .ram_axi_wready(ram_axi_wready),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: handshake with empty expectation queue", name);
  endtask

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    case (a)
      12'h040: return D040;
      12'h080: return D080;
      12'h100: return D100;
      default: return JUNK;
    endcase
  endfunction

  // Memory: arready one cycle after arvalid, rvalid two cycles after accept
  initial begin
    int m = 0;
    int dly = 0;
    logic ar_req, aw_req, ar_hs, r_hs, w_hs;
    logic [AW-1:0] a, lat_addr;
    lat_addr = '0;
    forever begin
      @(negedge clk);
      ar_req = ram_axi_arvalid;
      aw_req = ram_axi_awvalid && ram_axi_wvalid;
      ar_hs  = ram_axi_arvalid && ram_axi_arready;
      r_hs   = ram_axi_rvalid && ram_axi_rready;
      w_hs   = ram_axi_awvalid && ram_axi_awready && ram_axi_wvalid && ram_axi_wready;
      a      = ram_axi_araddr;
      @(posedge clk);
      #1;
      if (mem_mode != 0) begin
        ram_axi_arready = 1'b0;
        ram_axi_awready = 1'b0;
        ram_axi_wready  = 1'b0;
        ram_axi_rvalid  = (mem_mode == 2);
        ram_axi_rdata   = JUNK;
        m = 0;
      end else begin
        case (m)
          0: begin
            ram_axi_rvalid = 1'b0;
            if (ar_req) begin ram_axi_arready = 1'b1; m = 1; end
            else if (aw_req) begin ram_axi_awready = 1'b1; ram_axi_wready = 1'b1; m = 4; end
          end
          1: begin
            if (ar_hs) begin ram_axi_arready = 1'b0; lat_addr = a; dly = 2; m = 2; end
            else if (!ar_req) begin ram_axi_arready = 1'b0; m = 0; end
          end
          2: begin
            dly--;
            if (dly == 0) begin ram_axi_rvalid = 1'b1; ram_axi_rdata = mem_data(lat_addr); m = 3; end
          end
          3: if (r_hs) begin ram_axi_rvalid = 1'b0; m = 0; end
          4: if (w_hs) begin ram_axi_awready = 1'b0; ram_axi_wready = 1'b0; m = 0; end
          default: m = 0;
        endcase
      end
    end
  end

  // Monitor: isolation every cycle, scoreboard pops on each handshake
  initial begin
    ar_t e_ar;
    aw_t e_aw;
    logic leak;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("busy", busy, grant != 2'b00);
        leak = ((grant != 2'b01) && (i_arready || i_rvalid)) ||
               ((grant != 2'b10) && (d_arready || d_rvalid)) ||
               ((grant != 2'b11) && (d_awready || d_wready)) ||
               ((grant == 2'b00) && (ram_axi_arvalid || ram_axi_rready ||
                                     ram_axi_awvalid || ram_axi_wvalid));
        chk("isolation", leak, 1'b0);
        if (ram_axi_arvalid && ram_axi_arready) begin
          if (exp_ar.size() == 0) unexpected("ar");
          else begin
            e_ar = exp_ar.pop_front();
            chk("ar_grant", grant, e_ar.g);
            chk("ar_addr", ram_axi_araddr, e_ar.a);
          end
        end
        if (ram_axi_awvalid && ram_axi_awready && ram_axi_wvalid && ram_axi_wready) begin
          if (exp_aw.size() == 0) unexpected("aw");
          else begin
            e_aw = exp_aw.pop_front();
            chk("aw_addr", ram_axi_awaddr, e_aw.a);
            chk("w_data", ram_axi_wdata, e_aw.d);
          end
        end
        if (i_rvalid && i_rready) begin
          if (exp_ir.size() == 0) unexpected("i_r");
          else chk("i_rdata", i_rdata, exp_ir.pop_front());
        end
        if (d_rvalid && d_rready) begin
          if (exp_dr.size() == 0) unexpected("d_r");
          else chk("d_rdata", d_rdata, exp_dr.pop_front());
        end
      end
    end
  end

  task automatic i_read(input logic [AW-1:0] a);
    logic hs = 1'b0;
    i_araddr  = a;
    i_arvalid = 1'b1;
    for (int k = 0; k < 200 && !hs; k++) begin
      @(negedge clk); hs = i_arready;
      @(posedge clk); #1;
    end
    i_arvalid = 1'b0;
    chk("i_ar_accept", hs, 1'b1);
  endtask

  task automatic d_read(input logic [AW-1:0] a);
    logic hs = 1'b0;
    d_araddr  = a;
    d_arvalid = 1'b1;
    for (int k = 0; k < 200 && !hs; k++) begin
      @(negedge clk); hs = d_arready;
      @(posedge clk); #1;
    end
    d_arvalid = 1'b0;
    chk("d_ar_accept", hs, 1'b1);
  endtask

  task automatic d_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic hs = 1'b0;
    d_awaddr  = a;
    d_wdata   = d;
    d_awvalid = 1'b1;
    d_wvalid  = 1'b1;
    for (int k = 0; k < 200 && !hs; k++) begin
      @(negedge clk); hs = d_awready && d_wready;
      @(posedge clk); #1;
    end
    d_awvalid = 1'b0;
    d_wvalid  = 1'b0;
    chk("d_aw_accept", hs, 1'b1);
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 50 && grant != 2'b00; k++) begin
      @(posedge clk); #1;
    end
    chk(name, grant, 2'b00);
  endtask

  task automatic grant_after_one(input string name, input logic [1:0] g);
    @(posedge clk); #1;
    chk(name, grant, g);
  endtask

  initial begin
    int cnt;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_grant", grant, 2'b00);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_outs", {busy, timeout_err, ram_axi_arvalid, ram_axi_awvalid, ram_axi_wvalid,
                       ram_axi_rready, i_rvalid, d_rvalid, i_arready, d_arready}, '0);

    // ICache-only read
    exp_ar.push_back('{2'b01, 12'h040});
    exp_ir.push_back(D040);
    fork
      i_read(12'h040);
      grant_after_one("t1_grant", 2'b01);
    join
    wait_idle("t1_idle");

    // Simultaneous reads: DCache wins first
    exp_ar.push_back('{2'b10, 12'h080});
    exp_ar.push_back('{2'b01, 12'h040});
    exp_dr.push_back(D080);
    exp_ir.push_back(D040);
    fork
      i_read(12'h040);
      d_read(12'h080);
      grant_after_one("t2_grant", 2'b10);
    join
    wait_idle("t2_idle");

    // Write-back beats a concurrent DCache read
    exp_aw.push_back('{12'hFC0, WDAT});
    exp_ar.push_back('{2'b10, 12'h100});
    exp_dr.push_back(D100);
    fork
      d_write(12'hFC0, WDAT);
      d_read(12'h100);
      grant_after_one("t3_grant", 2'b11);
    join
    wait_idle("t3_idle");
    chk("t3_no_err", timeout_err, 1'b0);

    // Silent memory: watchdog abort after 8 granted cycles
    mem_mode  = 1;
    i_araddr  = 12'h040;
    i_arvalid = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (grant == 2'b01) cnt++;
      else if (cnt > 0) break;
    end
    i_arvalid = 1'b0;
    chk("t4_granted_cycles", cnt, 8);
    chk("t4_grant_released", grant, 2'b00);
    chk("t4_timeout_err", timeout_err, 1'b1);
    mem_mode = 2;
    repeat (3) begin @(posedge clk); #1; end
    chk("t4_stale_idle", grant, 2'b00);
    mem_mode = 0;
    @(posedge clk); #1;
    chk("t4_err_sticky", timeout_err, 1'b1);

    // Reset during a DCache read
    d_araddr  = 12'h100;
    d_arvalid = 1'b1;
    @(posedge clk); #1;
    chk("t5_grant", grant, 2'b10);
    rst = 1'b1;
    d_arvalid = 1'b0;
    @(posedge clk); #1;
    chk("t5_rst_outs", {grant, busy, ram_axi_arvalid, ram_axi_rready, d_rvalid}, '0);
    chk("t5_err_cleared", timeout_err, 1'b0);
    rst = 1'b0;
    repeat (4) begin @(posedge clk); #1; end

    // Both masters back-to-back, two reads each
`ifdef ARB_ROUND_ROBIN_EN
    exp_ar.push_back('{2'b10, 12'h080});
    exp_ar.push_back('{2'b01, 12'h040});
    exp_ar.push_back('{2'b10, 12'h100});
    exp_ar.push_back('{2'b01, 12'h040});
`else
    exp_ar.push_back('{2'b10, 12'h080});
    exp_ar.push_back('{2'b10, 12'h100});
    exp_ar.push_back('{2'b01, 12'h040});
    exp_ar.push_back('{2'b01, 12'h040});
`endif
    exp_dr.push_back(D080);
    exp_dr.push_back(D100);
    exp_ir.push_back(D040);
    exp_ir.push_back(D040);
    fork
      begin i_read(12'h040); i_read(12'h040); end
      begin d_read(12'h080); d_read(12'h100); end
    join
    wait_idle("t6_idle");
    repeat (2) begin @(posedge clk); #1; end
    chk("queues_drained", exp_ar.size() + exp_aw.size() + exp_ir.size() + exp_dr.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "global timeout");
  end

endmodule

`default_nettype wire
